// File: rtl/fast_accel_hls_deadlock_pkg.sv
// fast_accel_hls_deadlock_pkg: shared FSM encoding and defaults for the deadlock report unit
package fast_accel_hls_deadlock_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ORIGIN, S_TRACE, S_REPORT, S_DONE} state_e;
  localparam int DEF_TRACE_TIMEOUT = 64;
endpackage

// File: rtl/fast_accel_hls_deadlock_prio_sel.sv
// fast_accel_hls_deadlock_prio_sel: lowest-index priority select over a request vector
module fast_accel_hls_deadlock_prio_sel #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  output logic         any_o,
  output logic [W-1:0] idx_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) if (req_i[i]) idx_o = W'(i);
  end
  assign any_o = |req_i;
endmodule

// File: rtl/fast_accel_hls_deadlock_report_unit.sv
// fast_accel_hls_deadlock_report_unit: latches first deadlock, injects a trace token and reports its path
module fast_accel_hls_deadlock_report_unit
  import fast_accel_hls_deadlock_pkg::*;
#(
  parameter int PROC_NUM      = 4,
  parameter int PROC_ID_W     = 2,
  parameter int CNT_W         = 32,
  parameter int TRACE_TIMEOUT = DEF_TRACE_TIMEOUT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PROC_NUM-1:0]  dl_detect_in,
  input  logic [PROC_NUM-1:0]  token_in_vec,
  input  logic                 report_ready,
  output logic                 dl_detect_out,
  output logic [PROC_NUM-1:0]  origin,
  output logic                 token_clear,
  output logic                 report_valid,
  output logic [PROC_ID_W-1:0] report_proc_id,
  output logic [CNT_W-1:0]     report_cycle,
  output logic [CNT_W-1:0]     report_hops,
  output logic [PROC_NUM-1:0]  report_path,
  output logic                 report_timeout
);
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cyc_q, cyc_d, hops_q, hops_d;
  logic [PROC_ID_W-1:0]  sel_q, sel_d, req_idx;
  logic [PROC_NUM-1:0]   path_q, path_d;
  logic                  dl_q, dl_d, to_q, to_d, req_any, ret, expire;
  fast_accel_hls_deadlock_prio_sel #(.N(PROC_NUM), .W(PROC_ID_W)) u_sel (
    .req_i (dl_detect_in),
    .any_o (req_any),
    .idx_o (req_idx)
  );
  assign cnt_d  = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign ret    = token_in_vec[sel_q];
  // hops counts the current TRACE cycle, so the limit is hit on the TRACE_TIMEOUT-th cycle
  assign expire = (hops_q + 1'b1) == CNT_W'(TRACE_TIMEOUT);
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cyc_d       = cyc_q;
    hops_d      = hops_q;
    path_d      = path_q;
    dl_d        = dl_q;
    to_d        = to_q;
    token_clear = 1'b0;
    case (state_q)
      S_IDLE: if (req_any) begin
        sel_d   = req_idx;
        cyc_d   = cnt_q;
        dl_d    = 1'b1;
        state_d = S_ORIGIN;
      end
      S_ORIGIN: begin
        hops_d  = '0;
        path_d  = '0;
        state_d = S_TRACE;
      end
      S_TRACE: begin
        hops_d = hops_q + 1'b1;
        path_d = path_q | token_in_vec;
        if (ret || expire) begin
          token_clear = 1'b1;
          to_d        = !ret;
          state_d     = S_REPORT;
        end
      end
      S_REPORT: state_d = report_ready ? S_DONE : S_REPORT;
      default: ;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cyc_q   <= '0;
      hops_q  <= '0;
      sel_q   <= '0;
      path_q  <= '0;
      dl_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      hops_q  <= hops_d;
      sel_q   <= sel_d;
      path_q  <= path_d;
      dl_q    <= dl_d;
      to_q    <= to_d;
    end
  end
  assign origin         = (state_q == S_ORIGIN) ? PROC_NUM'(1) << sel_q : '0;
  assign report_valid   = state_q == S_REPORT;
  assign dl_detect_out  = dl_q;
  assign report_proc_id = sel_q;
  assign report_cycle   = cyc_q;
  assign report_hops    = hops_q;
  assign report_path    = path_q;
  assign report_timeout = to_q;
endmodule

// File: tb/tb_fast_accel_hls_deadlock_report_unit.sv
// tb_fast_accel_hls_deadlock_report_unit: directed checks of detection, trace, timeout, reset and DONE behaviour
module tb_fast_accel_hls_deadlock_report_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  dl_detect_in = '0, token_in_vec = '0, origin, report_path;
  logic        report_ready = 1'b0, dl_detect_out, token_clear, report_valid, report_timeout;
  logic [1:0]  report_proc_id;
  logic [31:0] report_cycle, report_hops;
  int n_chk = 0, n_err = 0;
  fast_accel_hls_deadlock_report_unit dut (
    .clock          (clock),
    .reset          (reset),
    .dl_detect_in   (dl_detect_in),
    .token_in_vec   (token_in_vec),
    .report_ready   (report_ready),
    .dl_detect_out  (dl_detect_out),
    .origin         (origin),
    .token_clear    (token_clear),
    .report_valid   (report_valid),
    .report_proc_id (report_proc_id),
    .report_cycle   (report_cycle),
    .report_hops    (report_hops),
    .report_path    (report_path),
    .report_timeout (report_timeout)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    dl_detect_in = '0;
    token_in_vec = '0;
    report_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask
  task automatic tok(input string tag, input logic [3:0] t, input logic exp_tc);
    @(negedge clock);
    token_in_vec = t;
    #1;
    check(tag, token_clear, exp_tc);
  endtask
  task automatic rep(input string tag, input logic [1:0] pid, input logic [31:0] cyc,
                     input logic [31:0] hops, input logic [3:0] path, input logic to);
    check({tag, "_valid"}, report_valid, 1'b1);
    check({tag, "_pid"}, report_proc_id, pid);
    check({tag, "_cycle"}, report_cycle, cyc);
    check({tag, "_hops"}, report_hops, hops);
    check({tag, "_path"}, report_path, path);
    check({tag, "_timeout"}, report_timeout, to);
  endtask
  task automatic accept(input string tag);
    report_ready = 1'b1;
    #1;
    check({tag, "_hs_valid"}, report_valid, 1'b1);
    @(negedge clock);
    report_ready = 1'b0;
    #1;
    check({tag, "_done_valid"}, report_valid, 1'b0);
    check({tag, "_done_dl"}, dl_detect_out, 1'b1);
  endtask
  initial begin
    do_reset();
    #1;
    check("rst_dl", dl_detect_out, 1'b0);
    check("rst_origin", origin, 4'b0000);
    check("rst_tc", token_clear, 1'b0);
    check("rst_valid", report_valid, 1'b0);
    check("rst_fields", {report_proc_id, report_cycle, report_hops, report_path, report_timeout}, '0);
    // single detect on process 1 at cycle 10
    repeat (10) @(negedge clock);
    dl_detect_in = 4'b0010;
    @(negedge clock);
    dl_detect_in = '0;
    #1;
    check("t1_dl", dl_detect_out, 1'b1);
    check("t1_origin", origin, 4'b0010);
    tok("t1_tok0", 4'b0100, 1'b0);
    check("t1_origin_off", origin, 4'b0000);
    tok("t1_tok1", 4'b1000, 1'b0);
    tok("t1_tok2", 4'b0001, 1'b0);
    tok("t1_tok3", 4'b0010, 1'b1);
    @(negedge clock);
    token_in_vec = '0;
    rep("t1", 2'd1, 32'd10, 32'd4, 4'b1111, 1'b0);
    accept("t1");
    // DONE ignores all further activity
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      dl_detect_in = 4'($urandom) | 4'b0001;
      token_in_vec = 4'($urandom);
      #1;
      check("done_origin", origin, 4'b0000);
      check("done_tc", token_clear, 1'b0);
      check("done_valid", report_valid, 1'b0);
      check("done_dl", dl_detect_out, 1'b1);
    end
    // lowest-index win and the REQ-040 style ring from process 0
    do_reset();
    repeat (5) @(negedge clock);
    dl_detect_in = 4'b1001;
    @(negedge clock);
    dl_detect_in = '0;
    #1;
    check("t3_origin", origin, 4'b0001);
    tok("t3_tok0", 4'b0010, 1'b0);
    tok("t3_tok1", 4'b0100, 1'b0);
    tok("t3_tok2", 4'b1000, 1'b0);
    tok("t3_tok3", 4'b0001, 1'b1);
    @(negedge clock);
    token_in_vec = '0;
    rep("t3", 2'd0, 32'd5, 32'd4, 4'b1111, 1'b0);
    accept("t3");
    // reset mid-trace, then a fresh detect with two simultaneous requests
    do_reset();
    repeat (2) @(negedge clock);
    dl_detect_in = 4'b0100;
    @(negedge clock);
    dl_detect_in = '0;
    tok("t4_tok0", 4'b0001, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    token_in_vec = 4'b0100;
    #1;
    check("t4_rst_dl", dl_detect_out, 1'b0);
    check("t4_rst_origin", origin, 4'b0000);
    check("t4_rst_tc", token_clear, 1'b0);
    check("t4_rst_valid", report_valid, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    token_in_vec = '0;
    repeat (3) @(negedge clock);
    dl_detect_in = 4'b0110;
    @(negedge clock);
    dl_detect_in = '0;
    #1;
    check("t4_origin", origin, 4'b0010);
    tok("t4_ret", 4'b0010, 1'b1);
    @(negedge clock);
    token_in_vec = '0;
    rep("t4", 2'd1, 32'd3, 32'd1, 4'b0010, 1'b0);
    accept("t4");
    // timeout with report held unaccepted for 5 cycles
    do_reset();
    repeat (2) @(negedge clock);
    dl_detect_in = 4'b1000;
    @(negedge clock);
    dl_detect_in = '0;
    #1;
    check("t5_origin", origin, 4'b1000);
    for (int i = 1; i <= 64; i++) begin
      @(negedge clock);
      token_in_vec = 4'b0001;
      #1;
      if (i == 1 || i == 63) check("t5_tc_early", token_clear, 1'b0);
      if (i == 64) check("t5_tc_timeout", token_clear, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      token_in_vec = '0;
      #1;
      rep("t5_hold", 2'd3, 32'd2, 32'd64, 4'b0001, 1'b1);
    end
    accept("t5");
    // return and timeout on the same cycle: return wins
    do_reset();
    dl_detect_in = 4'b0100;
    @(negedge clock);
    dl_detect_in = '0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clock);
      token_in_vec = (i == 64) ? 4'b0100 : 4'b0000;
      #1;
      if (i == 64) check("t6_tc", token_clear, 1'b1);
    end
    @(negedge clock);
    token_in_vec = '0;
    rep("t6", 2'd2, 32'd0, 32'd64, 4'b0100, 1'b0);
    accept("t6");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
